// File: rtl/serial_add_pkg.sv
// Shared constants for the bit-serial add/subtract controller:
// FSM state encodings and operation select values.
package serial_add_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// Single-bit full-adder cell used by the serial controller.
module serial_add_ctrl_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller. One full-adder cell is stepped over
// WIDTH cycles, LSB first, with the carry held in a register between bits.
// Subtract is a + ~b + 1: B is inverted on load and the carry seeded with 1.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic             carry_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;

  logic             accept_s;
  logic             run_s;
  logic             last_s;
  logic             fa_sum_s;
  logic             fa_co_s;

  // A new request is taken only when no operation is in flight.
  assign accept_s = start & ((state_r == ST_IDLE) | (state_r == ST_DONE));
  assign run_s    = (state_r == ST_RUN);
  assign last_s   = run_s & (cnt_r == CNT_LAST);

  serial_add_ctrl_fa u_fa (
    .a  (a_sh_r[0]),
    .b  (b_sh_r[0]),
    .ci (carry_r),
    .s  (fa_sum_s),
    .co (fa_co_s)
  );

  // Sequencing FSM, bit counter and registered busy/done flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_r <= ST_RUN;
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (cnt_r == CNT_LAST) begin
            // Counter holds at its last value so it never wraps.
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= {CNT_W{1'b0}};
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // Operand shift registers, carry register and sum shift register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sh_r  <= {WIDTH{1'b0}};
      b_sh_r  <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      sum_r   <= {WIDTH{1'b0}};
    end else if (accept_s) begin
      a_sh_r  <= a;
      b_sh_r  <= (op == OP_ADD) ? b : ~b;
      carry_r <= (op == OP_SUB) ? 1'b1 : cin;
    end else if (run_s) begin
      a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
      b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
      carry_r <= fa_co_s;
      sum_r   <= {fa_sum_s, sum_r[WIDTH-1:1]};
    end else begin
      carry_r <= carry_r;
    end
  end

  // Final carry and signed overflow, captured on the MSB step where
  // carry_r is the carry into the MSB and fa_co_s the carry out of it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (last_s) begin
      cout_r <= fa_co_s;
      ovf_r  <= carry_r ^ fa_co_s;
    end else begin
      cout_r <= cout_r;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): directed cases,
// handshake corner cases, mid-operation reset and random operations
// compared against an arithmetic reference model.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic         op;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_sum;
  logic         exp_cout;
  logic         exp_ovf;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .cin   (cin),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic top,
                       input logic tcin);
    int unsigned ua;
    int unsigned ub;
    int unsigned full;
    int sa;
    int sb;
    int sr;
    ua = ta;
    ub = tb_;
    sa = $signed(ta);
    sb = $signed(tb_);
    if (top == 1'b0) begin
      full     = ua + ub + tcin;
      exp_sum  = 8'(full);
      exp_cout = (full > 255);
      sr       = sa + sb + int'(tcin);
    end else begin
      exp_sum  = 8'(ua - ub);
      exp_cout = (ua >= ub);
      sr       = sa - sb;
    end
    exp_ovf = (sr > 127) || (sr < -128);
  endtask

  // Drive a request and return at the sample point just after its accept edge.
  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic top,
                        input logic tcin);
    @(negedge clk);
    a = ta; b = tb_; op = top; cin = tcin; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges (and busy samples) until done, bounded.
  task automatic wait_done(output int edges, output int busy_cnt);
    edges = 0;
    busy_cnt = 0;
    while (!done && edges < 40) begin
      if (busy) busy_cnt++;
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic check_result(input string tag);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    chk({tag, "_sum"}, 32'(sum), 32'(exp_sum));
    chk({tag, "_cout"}, 32'(cout), 32'(exp_cout));
    chk({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
  endtask

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic top,
                       input logic tcin, input string tag);
    int edges;
    int bc;
    model(ta, tb_, top, tcin);
    launch(ta, tb_, top, tcin);
    wait_done(edges, bc);
    chk({tag, "_latency"}, 32'(edges), 32'(W));
    chk({tag, "_busy_cycles"}, 32'(bc), 32'(W));
    check_result(tag);
  endtask

  initial begin
    int edges;
    int bc;
    int pre;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic rop;
    logic rcin;

    clk = 1'b0; reset = 1'b1; start = 1'b0; op = 1'b0; cin = 1'b0;
    a = '0; b = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed arithmetic cases.
    do_op(8'h35, 8'h4A, 1'b0, 1'b0, "add");
    @(posedge clk); #1;
    chk("done_pulse", 32'(done), 32'd0);
    chk("sum_held_idle", 32'(sum), 32'(exp_sum));
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, "wrap");
    do_op(8'hFF, 8'h01, 1'b0, 1'b1, "wrap_cin");
    do_op(8'h7F, 8'h01, 1'b0, 1'b0, "sovf");
    do_op(8'h05, 8'h07, 1'b1, 1'b1, "sub_borrow");

    // start during RUN is ignored.
    model(8'h12, 8'h34, 1'b0, 1'b0);
    launch(8'h12, 8'h34, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    a = 8'hAA; b = 8'h55; op = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pre = 3;
    wait_done(edges, bc);
    chk("ign_latency", 32'(pre + edges), 32'(W));
    check_result("ign");

    // start held in the DONE cycle is accepted back-to-back.
    model(8'hC3, 8'h3C, 1'b1, 1'b0);
    a = 8'hC3; b = 8'h3C; op = 1'b1; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    wait_done(edges, bc);
    chk("b2b_gap", 32'(edges + 1), 32'(W + 1));
    check_result("b2b");

    // Reset in the middle of an operation.
    launch(8'h99, 8'h66, 1'b0, 1'b1);
    repeat (4) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_sum", 32'(sum), 32'd0);
    chk("mid_rst_cout", 32'(cout), 32'd0);
    chk("mid_rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    do_op(8'h10, 8'h20, 1'b0, 1'b0, "post_rst");

    // Random operations.
    for (int i = 0; i < 24; i++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rop  = 1'($urandom);
      rcin = 1'($urandom);
      do_op(ra, rb, rop, rcin, "rand");
      if (($urandom & 32'd1) == 32'd1) begin
        @(posedge clk); #1;
        chk("rand_idle_done", 32'(done), 32'd0);
        chk("rand_idle_sum", 32'(sum), 32'(exp_sum));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
